led_matrix_serial_tx: RTL

Host-side serializer that drives the LED matrix driver's serial load interface (din, dclk, strobe). It accepts parallel words over a valid/ready handshake and shifts them out MSB-first on din, with a generated dclk. On request, it pulses strobe after a word so the driver latches its shift register. It sits in the bench/host subsystem and drives the driver's ui_in[0] (din), ui_in[1] (dclk) and ui_in[2] (strobe).

---
 rtl/led_matrix_serial_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/led_matrix_serial_tx.sv
// led_matrix_serial_tx
//   Serializer for the LED matrix driver's serial load interface. Takes parallel
//   words over a valid/ready handshake and shifts them out MSB-first on din with
//   a generated dclk. When a word is flagged with tx_last, a strobe pulse follows
//   it so the driver latches its shift register.
//
//   Handshake: a word is accepted on a rising clk edge where tx_valid && tx_ready.
//   tx_data/tx_last are captured on that edge; later changes are ignored. tx_valid
//   while tx_ready=0 is simply held off until the next accept. tx_ready is only
//   high in IDLE.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   word to transmit (MSB first)
//   tx_last   pulse strobe after this word
//   tx_valid  word offered
//   tx_ready  block can accept a word (IDLE only)
//   din       serial data, stable across each bit's low and high dclk phase
//   dclk      serial clock, driver samples din on its rising edge
//   strobe    latch pulse, never high together with dclk
//   busy      high in any state other than IDLE
module led_matrix_serial_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              din,
    output logic              dclk,
    output logic              strobe,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_STB  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                last_q, last_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                din_q, din_d;
    logic                dclk_q, dclk_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;
    // Holds tx_ready low until the first clk edge after reset release.
    logic                ready_en_q;

    logic                div_done;
    logic                accept;

    assign tx_ready = ready_en_q && (state_q == S_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign div_done = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_LO;
                    shift_d   = tx_data;
                    last_d    = tx_last;
                    bit_cnt_d = BIT_W'(DATA_W - 1);
                end
            end
            S_LO: begin
                if (div_done) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (div_done) begin
                    if (bit_cnt_q != '0) begin
                        // Next bit moves to the MSB as LO is re-entered, so din
                        // only ever changes while dclk is low.
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        state_d   = S_LO;
                    end else if (last_q) begin
                        state_d = S_STB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_STB: begin
                if (div_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Phase counter restarts on every state change and rests at 0 in IDLE.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        // Outputs are registered from the next state so they line up with it.
        din_d    = ((state_d == S_LO) || (state_d == S_HI)) ? shift_d[DATA_W-1] : 1'b0;
        dclk_d   = (state_d == S_HI);
        strobe_d = (state_d == S_STB);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            last_q     <= 1'b0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            din_q      <= 1'b0;
            dclk_q     <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            din_q      <= din_d;
            dclk_q     <= dclk_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            ready_en_q <= 1'b1;
        end
    end

    assign din    = din_q;
    assign dclk   = dclk_q;
    assign strobe = strobe_q;
    assign busy   = busy_q;

endmodule
